exe_wb_arbiter: RTL and testbench
=================================

# exe_wb_arbiter

Shares the single scalar writeback port of the execution stage between three result producers: ALU/branch (single-cycle), MUL (pipelined) and DIV (iterative). Each producer gets one holding slot. A priority arbiter with an optional anti-starvation guard drives a registered writeback output. Backpressure returns to each unit as a ready signal and to the control unit as a structural stall. The block sits between the functional units and the `exe_wb_scalar_instr_t` writeback interface.

## Interface
Parameters:
- `DATA_W`, 64, result data width
- `TAG_W`, 6, destination physical-register tag width
- `STARVE_LIMIT`, 4, waiting cycles before a source is promoted (guard builds only)

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  reset: synchronous, active-high
- `kill_i`  in  1  pipeline flush
- `{alu,mul,div}_valid_i`  in  1  each: producer presents a result
- `{alu,mul,div}_tag_i`  in  TAG_W  each: destination tag
- `{alu,mul,div}_data_i`  in  DATA_W  each: result
- `{alu,mul,div}_ready_o`  out  1  each: holding slot can accept this cycle
- `wb_valid_o`  out  1  writeback entry valid
- `wb_src_o`  out  2  granted source: 0 = ALU, 1 = MUL, 2 = DIV
- `wb_tag_o`  out  TAG_W  writeback tag
- `wb_data_o`  out  DATA_W  writeback data
- `wb_ready_i`  in  1  writeback consumer accepts the entry
- `stall_o`  out  1  structural stall to the control unit

## Operation
- Each source s has a holding slot: `buf_v[s]`, `buf_tag[s]`, `buf_data[s]`.
- `s_ready_o = !rst_i && !kill_i && (!buf_v[s] || grant[s])`.
- A transfer occurs when `valid_i && ready_o`. The slot loads at the edge.
- Output slot is free when `!wb_valid_o || wb_ready_i`.
- The arbiter grants exactly one valid slot only when the output slot is free. The granted slot is copied to the `wb_*` registers and its `buf_v` is cleared, unless it is refilled in the same cycle.
- Base priority is fixed: DIV > MUL > ALU.
- `wb_valid_o` clears on `wb_ready_i` if nothing is granted that cycle.
- `stall_o = !(alu_ready_o && mul_ready_o && div_ready_o)`.
- Kill: at the edge where `kill_i` is high, all `buf_v`, `wb_valid_o` and all starvation counters clear. Inputs presented in that cycle are dropped.
- A simultaneous refill and grant on the same slot is legal. The old entry leaves, the new entry loads, and no bubble is inserted.

## Timing
- Reset values: `wb_valid_o` = 0, `wb_src_o` = 0, `wb_tag_o` = 0, `wb_data_o` = 0. All `*_ready_o` = 0 while `rst_i` is high and 1 on the first cycle after. `stall_o` = 1 during reset and 0 after.
- Minimum latency: if input is accepted at edge k and the slot wins, `wb_valid_o` is high after edge k+1.
- An uncontended source sustains one result per cycle.
- With `wb_ready_i` held low, `wb_*` stay stable. Once all three slots fill, all readies drop and `stall_o` rises.
- Reset asserted mid-operation discards every buffered and output entry at that edge.

## Configuration
- `EXE_WB_ARB_STARVE_GUARD_EN` defined:
  - Each source has a saturating counter of width `$clog2(STARVE_LIMIT+1)`.
  - The counter increments each cycle the source's slot is valid, the output is free, and the source loses arbitration.
  - It clears on grant.
  - A source whose counter is ≥ `STARVE_LIMIT` is "starved". Starved sources outrank non-starved ones, ordered ALU > MUL > DIV among themselves.
- Macro undefined: no counters; pure fixed priority DIV > MUL > ALU.

## Structure
- Shared package (`drac_pkg`) holds:
  - the `wb_src_t` enum (`WB_SRC_ALU`, `WB_SRC_MUL`, `WB_SRC_DIV`)
  - a packed `wb_slot_t` struct {valid, tag, data}
  - the `WB_SRC_N = 3` constant
- One sub-module, `exe_wb_prio_sel`: combinational. It takes the valid vector and starved vector and returns a one-hot grant. The holding slots, output register and counters live in the top.

## Test plan
- ALU only, `wb_ready_i` = 1: 10 back-to-back results, tags 0..9 → `wb_valid_o` continuous from the second cycle, tags 0..9 in order, `wb_src_o` = 0, `stall_o` = 0.
- ALU, MUL and DIV valid in the same cycle (tags 1, 2, 3), guard off → writebacks carry tags 3, 2, 1 on consecutive cycles.
- `wb_ready_i` = 0 with all three slots filled → all readies 0, `stall_o` = 1, `wb_tag_o` stable. Raising `wb_ready_i` drains the slots one entry per cycle.
- Guard on, `STARVE_LIMIT` = 4, MUL and DIV each continuously valid, ALU holding tag 7 → ALU granted no later than the 5th eligible cycle after its entry is buffered.
- `kill_i` pulsed with three slots and the output full, and `alu_valid_i` = 1 with tag 9 in the same cycle → next cycle `wb_valid_o` = 0, every `buf_v` = 0, tag 9 never written back.
- `rst_i` asserted mid-drain → next cycle all outputs at reset values; one cycle after release, readies = 1.

Source files
------------

// File: rtl/drac_pkg.sv
// -----------------------------------------------------------------------------
// drac_pkg
// Shared execution-stage writeback definitions.
//   wb_src_t       : writeback source encoding (ALU = 0, MUL = 1, DIV = 2)
//   wb_slot_t      : one writeback entry {valid, tag, data} at default widths
//   WB_SRC_N       : number of writeback producers
//   onehot_to_src  : converts a one-hot grant vector to a wb_src_t
// -----------------------------------------------------------------------------
package drac_pkg;

  localparam int WB_SRC_N  = 3;
  localparam int WB_TAG_W  = 6;
  localparam int WB_DATA_W = 64;

  // Values double as bit positions in every per-source vector.
  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MUL = 2'd1,
    WB_SRC_DIV = 2'd2
  } wb_src_t;

  typedef struct packed {
    logic                 valid;
    logic [WB_TAG_W-1:0]  tag;
    logic [WB_DATA_W-1:0] data;
  } wb_slot_t;

  function automatic wb_src_t onehot_to_src(input logic [WB_SRC_N-1:0] oh);
    if (oh[WB_SRC_DIV]) return WB_SRC_DIV;
    if (oh[WB_SRC_MUL]) return WB_SRC_MUL;
    return WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/exe_wb_prio_sel.sv
// -----------------------------------------------------------------------------
// exe_wb_prio_sel
// Combinational writeback priority selector.
//   valid   [in ]  slots competing this cycle (already gated by output-free)
//   starved [in ]  slots promoted by the anti-starvation guard
//   grant   [out]  one-hot grant, or zero when nothing is valid
// Starved slots win first, ALU > MUL > DIV among themselves; otherwise the
// fixed order DIV > MUL > ALU applies.
// -----------------------------------------------------------------------------
module exe_wb_prio_sel
  import drac_pkg::*;
(
  input  logic [WB_SRC_N-1:0] valid,
  input  logic [WB_SRC_N-1:0] starved,
  output logic [WB_SRC_N-1:0] grant
);

  logic [WB_SRC_N-1:0] urgent;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    grant  = '0;
    urgent = valid & starved;
    if (|urgent) begin
      if      (urgent[WB_SRC_ALU]) grant[WB_SRC_ALU] = 1'b1;
      else if (urgent[WB_SRC_MUL]) grant[WB_SRC_MUL] = 1'b1;
      else                         grant[WB_SRC_DIV] = 1'b1;
    end else begin
      if      (valid[WB_SRC_DIV])  grant[WB_SRC_DIV] = 1'b1;
      else if (valid[WB_SRC_MUL])  grant[WB_SRC_MUL] = 1'b1;
      else if (valid[WB_SRC_ALU])  grant[WB_SRC_ALU] = 1'b1;
    end
  end

endmodule

// File: rtl/exe_wb_arbiter.sv
// -----------------------------------------------------------------------------
// exe_wb_arbiter
// Shares the scalar execution-stage writeback port between the ALU, MUL and
// DIV producers. Each producer owns one holding slot; a priority selector
// moves one slot per cycle into the registered wb_* output.
//   clk_i, rst_i (sync, active-high), kill_i (flush: drops slots and output)
//   {alu,mul,div}_valid_i/_tag_i/_data_i  producer results
//   {alu,mul,div}_ready_o                 holding slot can accept this cycle
//   wb_valid_o/wb_src_o/wb_tag_o/wb_data_o  registered writeback entry
//   wb_ready_i                            consumer accepts the entry
//   stall_o                               any producer blocked
// Build option: EXE_WB_ARB_STARVE_GUARD_EN adds per-source saturating wait
// counters; a source waiting STARVE_LIMIT eligible cycles is promoted.
// -----------------------------------------------------------------------------
module exe_wb_arbiter
  import drac_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int TAG_W        = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              kill_i,
  input  logic              alu_valid_i,
  input  logic [TAG_W-1:0]  alu_tag_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              mul_valid_i,
  input  logic [TAG_W-1:0]  mul_tag_i,
  input  logic [DATA_W-1:0] mul_data_i,
  output logic              mul_ready_o,
  input  logic              div_valid_i,
  input  logic [TAG_W-1:0]  div_tag_i,
  input  logic [DATA_W-1:0] div_data_i,
  output logic              div_ready_o,
  output logic              wb_valid_o,
  output logic [1:0]        wb_src_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [DATA_W-1:0] wb_data_o,
  input  logic              wb_ready_i,
  output logic              stall_o
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  logic [WB_SRC_N-1:0] in_valid, ready, load, buf_v, eligible, grant, starved;
  logic [TAG_W-1:0]    in_tag   [WB_SRC_N];
  logic [DATA_W-1:0]   in_data  [WB_SRC_N];
  logic [TAG_W-1:0]    buf_tag  [WB_SRC_N];
  logic [DATA_W-1:0]   buf_data [WB_SRC_N];
  logic [TAG_W-1:0]    sel_tag;
  logic [DATA_W-1:0]   sel_data;
  logic                out_free;

  assign in_valid = {div_valid_i, mul_valid_i, alu_valid_i};
  assign in_tag   = '{alu_tag_i,  mul_tag_i,  div_tag_i};
  assign in_data  = '{alu_data_i, mul_data_i, div_data_i};

  assign out_free = !wb_valid_o || wb_ready_i;
  assign eligible = out_free ? buf_v : '0;

  exe_wb_prio_sel u_prio_sel (
    .valid   (eligible),
    .starved (starved),
    .grant   (grant)
  );

  // A slot being granted this cycle can take a new entry with no bubble.
  assign ready = {WB_SRC_N{!rst_i && !kill_i}} & (~buf_v | grant);
  assign load  = in_valid & ready;

  assign alu_ready_o = ready[WB_SRC_ALU];
  assign mul_ready_o = ready[WB_SRC_MUL];
  assign div_ready_o = ready[WB_SRC_DIV];
  assign stall_o     = !(&ready);

  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    for (int s = 0; s < WB_SRC_N; s++) begin
      if (grant[s]) begin
        sel_tag  = buf_tag[s];
        sel_data = buf_data[s];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i || kill_i) begin
      buf_v <= '0;
    end else begin
      for (int s = 0; s < WB_SRC_N; s++) begin
        if (load[s])       buf_v[s] <= 1'b1;
        else if (grant[s]) buf_v[s] <= 1'b0;
      end
    end
  end

  // NOTE: slot payload is not reset; buf_v alone qualifies it, which keeps
  // reset off the wide data flops.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < WB_SRC_N; s++) begin
      if (load[s]) begin
        buf_tag[s]  <= in_tag[s];
        buf_data[s] <= in_data[s];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o <= 1'b0;
      wb_src_o   <= '0;
      wb_tag_o   <= '0;
      wb_data_o  <= '0;
    end else if (kill_i) begin
      wb_valid_o <= 1'b0;
    end else if (|grant) begin
      wb_valid_o <= 1'b1;
      wb_src_o   <= onehot_to_src(grant);
      wb_tag_o   <= sel_tag;
      wb_data_o  <= sel_data;
    end else if (wb_ready_i) begin
      wb_valid_o <= 1'b0;
    end
  end

`ifdef EXE_WB_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt [WB_SRC_N];

  // Counts cycles a slot competed for a free output and lost.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < WB_SRC_N; s++) begin
      if (rst_i || kill_i || grant[s])          starve_cnt[s] <= '0;
      else if (eligible[s] && starve_cnt[s] != '1) starve_cnt[s] <= starve_cnt[s] + CNT_W'(1);
    end
  end

  always_comb begin
    starved = '0;
    for (int s = 0; s < WB_SRC_N; s++) begin
      starved[s] = (starve_cnt[s] >= CNT_W'(STARVE_LIMIT));
    end
  end
`else
  assign starved = '0;
`endif

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_exe_wb_arbiter
// Producers are modelled as queues of pending results that hold valid until
// accepted. A reference model tracks slot occupancy and the output entry from
// the arbitration rules and is compared every cycle; directed scenarios also
// check the observed writeback order against fixed sequences.
// -----------------------------------------------------------------------------
module tb_exe_wb_arbiter;
  import drac_pkg::*;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 6;
  localparam int LIMIT  = 4;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } item_t;

  logic              clk_i = 1'b0;
  logic              rst_i, kill_i, wb_ready_i;
  logic [2:0]        v_in;
  logic [TAG_W-1:0]  tag_in  [3];
  logic [DATA_W-1:0] data_in [3];
  logic              alu_rdy, mul_rdy, div_rdy;
  logic [2:0]        rdy;
  logic              wb_valid_o, stall_o;
  logic [1:0]        wb_src_o;
  logic [TAG_W-1:0]  wb_tag_o;
  logic [DATA_W-1:0] wb_data_o;

  assign rdy = {div_rdy, mul_rdy, alu_rdy};

  always #5 clk_i = ~clk_i;

  exe_wb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .kill_i      (kill_i),
    .alu_valid_i (v_in[0]), .alu_tag_i (tag_in[0]), .alu_data_i (data_in[0]), .alu_ready_o (alu_rdy),
    .mul_valid_i (v_in[1]), .mul_tag_i (tag_in[1]), .mul_data_i (data_in[1]), .mul_ready_o (mul_rdy),
    .div_valid_i (v_in[2]), .div_tag_i (tag_in[2]), .div_data_i (data_in[2]), .div_ready_o (div_rdy),
    .wb_valid_o  (wb_valid_o),
    .wb_src_o    (wb_src_o),
    .wb_tag_o    (wb_tag_o),
    .wb_data_o   (wb_data_o),
    .wb_ready_i  (wb_ready_i),
    .stall_o     (stall_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Producer queues and observed writeback log.
  item_t            src_q [3][$];
  logic [TAG_W-1:0] wb_log [$];

  // Reference model state.
  bit                m_v [3];
  item_t             m_slot [3];
  int                m_cnt [3];
  bit                m_wb_v;
  int                m_wb_src;
  logic [TAG_W-1:0]  m_wb_tag;
  logic [DATA_W-1:0] m_wb_data;

  // Winner among occupied slots when the output can take an entry, else -1.
  function automatic int m_pick(input bit free);
    if (!free) return -1;
`ifdef EXE_WB_ARB_STARVE_GUARD_EN
    for (int s = 0; s < 3; s++)
      if (m_v[s] && m_cnt[s] >= LIMIT) return s;
`endif
    for (int s = 2; s >= 0; s--)
      if (m_v[s]) return s;
    return -1;
  endfunction

  task automatic push(input int s, input logic [TAG_W-1:0] tag);
    item_t it;
    it.tag  = tag;
    it.data = {$urandom, $urandom};
    src_q[s].push_back(it);
  endtask

  task automatic clear_queues();
    for (int s = 0; s < 3; s++) src_q[s].delete();
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step();
    bit         free;
    int         pick;
    logic [2:0] er;
    for (int s = 0; s < 3; s++) begin
      v_in[s] = (src_q[s].size() > 0);
      if (v_in[s]) begin
        tag_in[s]  = src_q[s][0].tag;
        data_in[s] = src_q[s][0].data;
      end else begin
        tag_in[s]  = TAG_W'($urandom);
        data_in[s] = {$urandom, $urandom};
      end
    end
    #1;
    free = !m_wb_v || wb_ready_i;
    pick = m_pick(free);
    for (int s = 0; s < 3; s++) er[s] = !rst_i && !kill_i && (!m_v[s] || pick == s);
    check("ready", 64'(rdy), 64'(er));
    check("stall", 64'(stall_o), 64'(!(&er)));
    check("wb_valid", 64'(wb_valid_o), 64'(m_wb_v));
    if (m_wb_v) begin
      check("wb_src", 64'(wb_src_o), 64'(m_wb_src));
      check("wb_tag", 64'(wb_tag_o), 64'(m_wb_tag));
      check("wb_data", wb_data_o, m_wb_data);
    end
    if (wb_valid_o && wb_ready_i) wb_log.push_back(wb_tag_o);
    @(posedge clk_i);
    if (rst_i) begin
      for (int s = 0; s < 3; s++) begin m_v[s] = 0; m_cnt[s] = 0; end
      m_wb_v = 0; m_wb_src = 0; m_wb_tag = '0; m_wb_data = '0;
    end else if (kill_i) begin
      for (int s = 0; s < 3; s++) begin m_v[s] = 0; m_cnt[s] = 0; end
      m_wb_v = 0;
    end else begin
      for (int s = 0; s < 3; s++) begin
        if (pick == s) m_cnt[s] = 0;
        else if (m_v[s] && free && m_cnt[s] < LIMIT) m_cnt[s]++;
      end
      if (pick >= 0) begin
        m_wb_v = 1; m_wb_src = pick;
        m_wb_tag = m_slot[pick].tag; m_wb_data = m_slot[pick].data;
        m_v[pick] = 0;
      end else if (wb_ready_i) begin
        m_wb_v = 0;
      end
      for (int s = 0; s < 3; s++) begin
        if (v_in[s] && er[s]) begin
          m_v[s] = 1;
          m_slot[s] = src_q[s][0];
        end
      end
    end
    for (int s = 0; s < 3; s++)
      if (v_in[s] && er[s]) void'(src_q[s].pop_front());
    @(negedge clk_i);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int pos;
    int n9;
    rst_i = 1'b1; kill_i = 1'b0; wb_ready_i = 1'b1;
    v_in = '0;
    for (int s = 0; s < 3; s++) begin tag_in[s] = '0; data_in[s] = '0; end
    @(negedge clk_i);

    // Reset state.
    run(2);
    check("rst_wb_tag", 64'(wb_tag_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd1);
    rst_i = 1'b0;

    // ALU only, back-to-back tags 0..9.
    wb_log.delete();
    for (int i = 0; i < 10; i++) push(0, TAG_W'(i));
    run(13);
    check("alu_stream_len", 64'(wb_log.size()), 64'd10);
    for (int i = 0; i < 10 && i < wb_log.size(); i++) check("alu_stream_tag", 64'(wb_log[i]), 64'(i));

    // Simultaneous ALU/MUL/DIV: DIV first, then MUL, then ALU.
    wb_log.delete();
    push(0, 6'd1); push(1, 6'd2); push(2, 6'd3);
    run(5);
    check("prio_len", 64'(wb_log.size()), 64'd3);
    if (wb_log.size() == 3) begin
      check("prio_first", 64'(wb_log[0]), 64'd3);
      check("prio_second", 64'(wb_log[1]), 64'd2);
      check("prio_third", 64'(wb_log[2]), 64'd1);
    end

    // Backpressure until every slot is full, then drain.
    wb_log.delete();
    wb_ready_i = 1'b0;
    push(0, 6'd20); push(1, 6'd21); push(2, 6'd22); push(2, 6'd23);
    run(6);
    #1;
    check("bp_ready", 64'(rdy), 64'd0);
    check("bp_stall", 64'(stall_o), 64'd1);
    check("bp_tag_held", 64'(wb_tag_o), 64'd22);
    @(negedge clk_i);
    wb_ready_i = 1'b1;
    run(6);
    check("drain_len", 64'(wb_log.size()), 64'd4);
    if (wb_log.size() == 4) begin
      check("drain_0", 64'(wb_log[0]), 64'd22);
      check("drain_1", 64'(wb_log[1]), 64'd23);
      check("drain_2", 64'(wb_log[2]), 64'd21);
      check("drain_3", 64'(wb_log[3]), 64'd20);
    end

`ifdef EXE_WB_ARB_STARVE_GUARD_EN
    // MUL and DIV saturate the port; ALU tag 7 wins on its 5th eligible cycle.
    wb_log.delete();
    push(0, 6'd7);
    for (int i = 0; i < 12; i++) begin push(1, 6'd32); push(2, 6'd33); end
    run(32);
    pos = -1;
    for (int i = 0; i < wb_log.size(); i++) if (pos < 0 && wb_log[i] == 6'd7) pos = i;
    check("starve_alu_pos", 64'(pos), 64'd4);
`endif

    // Kill with all slots and the output full; ALU tag 9 in the same cycle.
    wb_ready_i = 1'b0;
    push(0, 6'd30); push(1, 6'd31); push(2, 6'd32); push(2, 6'd33);
    run(5);
    clear_queues();
    push(0, 6'd9);
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    clear_queues();
    check("kill_wb_valid", 64'(wb_valid_o), 64'd0);
    wb_log.delete();
    wb_ready_i = 1'b1;
    run(5);
    n9 = 0;
    foreach (wb_log[i]) if (wb_log[i] == 6'd9) n9++;
    check("kill_tag9_dropped", 64'(n9), 64'd0);
    check("kill_nothing_left", 64'(wb_log.size()), 64'd0);

    // Reset in the middle of a drain.
    wb_ready_i = 1'b0;
    push(0, 6'd40); push(1, 6'd41); push(2, 6'd42); push(2, 6'd43);
    run(5);
    wb_ready_i = 1'b1;
    step();
    rst_i = 1'b1;
    clear_queues();
    step();
    check("mid_rst_valid", 64'(wb_valid_o), 64'd0);
    check("mid_rst_src", 64'(wb_src_o), 64'd0);
    check("mid_rst_tag", 64'(wb_tag_o), 64'd0);
    check("mid_rst_data", wb_data_o, 64'd0);
    rst_i = 1'b0;
    run(2);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 3; s++)
        if ($urandom_range(0, 2) == 0 && src_q[s].size() < 3) push(s, TAG_W'($urandom));
      wb_ready_i = ($urandom_range(0, 3) != 0);
      kill_i     = ($urandom_range(0, 49) == 0);
      step();
      if (kill_i) clear_queues();
      kill_i = 1'b0;
    end
    wb_ready_i = 1'b1;
    run(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
